// File: rtl/major_state_seq_pkg.sv
// Shared PDP-8/e major-state encodings and opcode constants for the sequencer,
// pc, ma and the testbenches.
package major_state_seq_pkg;

  typedef enum logic [3:0] {
    ST_F0 = 4'd0,
    ST_F1 = 4'd1,
    ST_F2 = 4'd2,
    ST_F3 = 4'd3,
    ST_D0 = 4'd4,
    ST_D1 = 4'd5,
    ST_D2 = 4'd6,
    ST_D3 = 4'd7,
    ST_E0 = 4'd8,
    ST_E1 = 4'd9,
    ST_E2 = 4'd10,
    ST_E3 = 4'd11,
    ST_H0 = 4'd12
  } state_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  // Memory-reference instructions (including JMP) go through defer when indirect.
  function automatic logic f3_to_defer(input logic [2:0] op, input logic ind);
    return ind && (op <= OP_JMP);
  endfunction

  function automatic logic f3_to_exec(input logic [2:0] op, input logic ind);
    return !ind && (op <= OP_JMS);
  endfunction

endpackage

// File: rtl/major_state_seq_boundary_sel.sv
// Instruction-boundary resolution: chooses H0 or F0 and whether an interrupt
// is granted. Purely combinational so the front-panel logic can share it.
module boundary_sel
  import major_state_seq_pkg::*;
(
  input  logic [0:11] instruction,
  input  logic        halt_req,
  input  logic        sing_step,
  input  logic        int_req,
  input  logic        int_ena,
  output state_e      next_state,
  output logic        int_grant
);

  logic w_is_hlt;
  logic w_unused_bits;

  // HLT is OPR group 2 (bit 3 set, bit 11 clear) with bit 10 set.
  assign w_is_hlt = (instruction[0:2] == OP_OPR) && instruction[3] &&
                    !instruction[11] && instruction[10];
  assign w_unused_bits = ^instruction[4:9];

  always_comb begin
    next_state = ST_F0;
    int_grant  = 1'b0;
    if (w_is_hlt || halt_req || sing_step) begin
      next_state = ST_H0;
    end else if (int_req && int_ena) begin
      int_grant = 1'b1;
    end
  end

endmodule

// File: rtl/major_state_seq.sv
// PDP-8/e major-state sequencer: fetch/defer/execute/halt cycles, run/halt,
// single-step and interrupt grant at instruction boundaries.
module major_state_seq
  import major_state_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [0:11] instruction,
  input  logic        run_req,
  input  logic        halt_req,
  input  logic        sing_step,
  input  logic        int_req,
  input  logic        int_ena,
  output logic [3:0]  state,
  output logic        running,
  output logic        int_ack,
  output logic        instr_done
);

  state_e     r_state;
  state_e     w_next;
  state_e     w_bnd_state;
  logic       r_running;
  logic       r_int_ack;
  logic       r_instr_done;
  logic       w_bnd_grant;
  logic       w_at_bnd;
  logic       w_done_next;
  logic [2:0] w_op;
  logic       w_ind;

  assign w_op  = instruction[0:2];
  assign w_ind = instruction[3];

  boundary_sel u_boundary_sel (
    .instruction (instruction),
    .halt_req    (halt_req),
    .sing_step   (sing_step),
    .int_req     (int_req),
    .int_ena     (int_ena),
    .next_state  (w_bnd_state),
    .int_grant   (w_bnd_grant)
  );

  always_comb begin
    w_next   = ST_H0;
    w_at_bnd = 1'b0;
    case (r_state)
      ST_F0: w_next = ST_F1;
      ST_F1: w_next = ST_F2;
      ST_F2: w_next = ST_F3;
      ST_F3: begin
        if (f3_to_defer(w_op, w_ind))     w_next = ST_D0;
        else if (f3_to_exec(w_op, w_ind)) w_next = ST_E0;
        else begin
          w_next   = w_bnd_state;
          w_at_bnd = 1'b1;
        end
      end
      ST_D0: w_next = ST_D1;
      ST_D1: w_next = ST_D2;
      ST_D2: w_next = ST_D3;
      ST_D3: begin
        if (w_op == OP_JMP) begin
          w_next   = w_bnd_state;
          w_at_bnd = 1'b1;
        end else begin
          w_next = ST_E0;
        end
      end
      ST_E0: w_next = ST_E1;
      ST_E1: w_next = ST_E2;
      ST_E2: w_next = ST_E3;
      ST_E3: begin
        w_next   = w_bnd_state;
        w_at_bnd = 1'b1;
      end
      ST_H0: w_next = (run_req && !halt_req) ? ST_F0 : ST_H0;
      default: w_next = ST_H0;
    endcase
  end

  // instr_done is registered, so predict whether the state being entered is a
  // boundary cycle; the IR is already stable by the time F3/D3/E3 is entered.
  always_comb begin
    w_done_next = 1'b0;
    case (w_next)
      ST_F3:   w_done_next = !f3_to_defer(w_op, w_ind) && !f3_to_exec(w_op, w_ind);
      ST_D3:   w_done_next = (w_op == OP_JMP);
      ST_E3:   w_done_next = 1'b1;
      default: w_done_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_H0;
      r_running    <= 1'b0;
      r_int_ack    <= 1'b0;
      r_instr_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_running    <= (w_next != ST_H0);
      r_int_ack    <= w_at_bnd && w_bnd_grant;
      r_instr_done <= w_done_next;
    end
  end

  assign state      = r_state;
  assign running    = r_running;
  assign int_ack    = r_int_ack;
  assign instr_done = r_instr_done;

endmodule

// File: tb/tb_major_state_seq.sv
// Directed self-checking bench for major_state_seq: a cycle-by-cycle trace
// table plus hand-written interrupt, halt, reset and single-step sequences.
module tb_major_state_seq;
  import major_state_seq_pkg::*;

  typedef struct {
    logic        rst, run, hlt, ss, irq, ien;
    logic [0:11] ins;
    logic [3:0]  st;
    logic        rn, ack, dn;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:11] instruction = 12'o7000;
  logic        run_req = 1'b0, halt_req = 1'b0, sing_step = 1'b0;
  logic        int_req = 1'b0, int_ena = 1'b0;
  logic [3:0]  state;
  logic        running, int_ack, instr_done;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  vec_t        tbl[$];

  major_state_seq dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .sing_step   (sing_step),
    .int_req     (int_req),
    .int_ena     (int_ena),
    .state       (state),
    .running     (running),
    .int_ack     (int_ack),
    .instr_done  (instr_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, run, hlt, ss, irq, ien,
                              input logic [0:11] ins, input logic [3:0] st,
                              input logic rn, ack, dn);
    vec_t v;
    v.rst = rst; v.run = run; v.hlt = hlt; v.ss = ss; v.irq = irq; v.ien = ien;
    v.ins = ins; v.st = st; v.rn = rn; v.ack = ack; v.dn = dn;
    return v;
  endfunction

  // Inputs are driven for the cycle before an edge; outputs checked 1ns after it.
  task automatic apply(input vec_t v, input string name);
    reset = v.rst; run_req = v.run; halt_req = v.hlt; sing_step = v.ss;
    int_req = v.irq; int_ena = v.ien; instruction = v.ins;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({state, running, int_ack, instr_done} !== {v.st, v.rn, v.ack, v.dn}) begin
      n_err++;
      $display("FAIL %s: got state=%0d running=%b int_ack=%b instr_done=%b, expected state=%0d running=%b int_ack=%b instr_done=%b",
               name, state, running, int_ack, instr_done, v.st, v.rn, v.ack, v.dn);
    end
  endtask

  task automatic add(input logic rst, run, hlt, ss, irq, ien, input logic [0:11] ins,
                     input logic [3:0] st, input logic rn, ack, dn);
    tbl.push_back(mk(rst, run, hlt, ss, irq, ien, ins, st, rn, ack, dn));
  endtask

  initial begin
    // reset, then OPR 7000 from a run request
    add(1,0,0,0,0,0,12'o7000, ST_H0,0,0,0);
    add(0,1,0,0,0,0,12'o7000, ST_F0,1,0,0);
    add(0,0,0,0,0,0,12'o7000, ST_F1,1,0,0);
    add(0,0,0,0,0,0,12'o7000, ST_F2,1,0,0);
    add(0,0,0,0,0,0,12'o7000, ST_F3,1,0,1);
    add(0,0,0,0,0,0,12'o7000, ST_F0,1,0,0);
    // TAD I: 12 cycles, one instr_done at E3
    add(0,0,0,0,0,0,12'o1455, ST_F1,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_F2,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_F3,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_D0,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_D1,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_D2,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_D3,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_E0,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_E1,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_E2,1,0,0);
    add(0,0,0,0,0,0,12'o1455, ST_E3,1,0,1);
    add(0,0,0,0,0,0,12'o1455, ST_F0,1,0,0);
    // JMP I: boundary at D3
    add(0,0,0,0,0,0,12'o5455, ST_F1,1,0,0);
    add(0,0,0,0,0,0,12'o5455, ST_F2,1,0,0);
    add(0,0,0,0,0,0,12'o5455, ST_F3,1,0,0);
    add(0,0,0,0,0,0,12'o5455, ST_D0,1,0,0);
    add(0,0,0,0,0,0,12'o5455, ST_D1,1,0,0);
    add(0,0,0,0,0,0,12'o5455, ST_D2,1,0,0);
    add(0,0,0,0,0,0,12'o5455, ST_D3,1,0,1);
    add(0,0,0,0,0,0,12'o5455, ST_F0,1,0,0);
    // JMP direct: boundary at F3
    add(0,0,0,0,0,0,12'o5177, ST_F1,1,0,0);
    add(0,0,0,0,0,0,12'o5177, ST_F2,1,0,0);
    add(0,0,0,0,0,0,12'o5177, ST_F3,1,0,1);
    add(0,0,0,0,0,0,12'o5177, ST_F0,1,0,0);
    // HLT, stay halted, restart with 1-clock latency; run_req ignored while running
    add(0,0,0,0,0,0,12'o7402, ST_F1,1,0,0);
    add(0,0,0,0,0,0,12'o7402, ST_F2,1,0,0);
    add(0,0,0,0,0,0,12'o7402, ST_F3,1,0,1);
    add(0,0,0,0,0,0,12'o7402, ST_H0,0,0,0);
    add(0,0,0,0,0,0,12'o7402, ST_H0,0,0,0);
    add(0,1,0,0,0,0,12'o7402, ST_F0,1,0,0);
    add(0,1,0,0,0,0,12'o7000, ST_F1,1,0,0);
    add(0,1,0,0,0,0,12'o7000, ST_F2,1,0,0);
    add(0,1,0,0,0,0,12'o7000, ST_F3,1,0,1);
    add(0,1,0,0,0,0,12'o7000, ST_F0,1,0,0);

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // ISZ with interrupt pending at E3: grant pulse on the following F0 only
    apply(mk(0,0,0,0,0,0,12'o2000, ST_F1,1,0,0), "isz_f1");
    apply(mk(0,0,0,0,0,0,12'o2000, ST_F2,1,0,0), "isz_f2");
    apply(mk(0,0,0,0,0,0,12'o2000, ST_F3,1,0,0), "isz_f3");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_E0,1,0,0), "isz_e0");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_E1,1,0,0), "isz_e1");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_E2,1,0,0), "isz_e2");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_E3,1,0,1), "isz_e3");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_F0,1,1,0), "int_ack_f0");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_F1,1,0,0), "int_ack_drop");

    // Same instruction with halt_req held: runs to completion, then H0, no grant
    apply(mk(0,0,1,0,1,1,12'o2000, ST_F2,1,0,0), "hlt_f2");
    apply(mk(0,0,1,0,1,1,12'o2000, ST_F3,1,0,0), "hlt_f3");
    apply(mk(0,0,1,0,1,1,12'o2000, ST_E0,1,0,0), "hlt_e0");
    apply(mk(0,0,1,0,1,1,12'o2000, ST_E1,1,0,0), "hlt_e1");
    apply(mk(0,0,1,0,1,1,12'o2000, ST_E2,1,0,0), "hlt_e2");
    apply(mk(0,0,1,0,1,1,12'o2000, ST_E3,1,0,1), "hlt_e3");
    apply(mk(0,0,1,0,1,1,12'o2000, ST_H0,0,0,0), "hlt_h0_no_ack");

    // In H0: run+halt together holds; interrupts never granted; run alone starts
    apply(mk(0,1,1,0,1,1,12'o2000, ST_H0,0,0,0), "h0_run_and_halt");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_H0,0,0,0), "h0_no_int");
    apply(mk(0,1,0,0,1,1,12'o2000, ST_F0,1,0,0), "h0_restart");

    // Request dropped before the boundary is not granted
    apply(mk(0,0,0,0,1,1,12'o2000, ST_F1,1,0,0), "drop_f1");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_F2,1,0,0), "drop_f2");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_F3,1,0,0), "drop_f3");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_E0,1,0,0), "drop_e0");
    apply(mk(0,0,0,0,1,1,12'o2000, ST_E1,1,0,0), "drop_e1");
    apply(mk(0,0,0,0,0,1,12'o2000, ST_E2,1,0,0), "drop_e2");
    apply(mk(0,0,0,0,0,1,12'o2000, ST_E3,1,0,1), "drop_e3");
    apply(mk(0,0,0,0,0,1,12'o2000, ST_F0,1,0,0), "drop_f0_no_ack");

    // Reset during E1 aborts to H0 with reset output values
    apply(mk(0,0,0,0,0,0,12'o2000, ST_F1,1,0,0), "rst_f1");
    apply(mk(0,0,0,0,0,0,12'o2000, ST_F2,1,0,0), "rst_f2");
    apply(mk(0,0,0,0,0,0,12'o2000, ST_F3,1,0,0), "rst_f3");
    apply(mk(0,0,0,0,0,0,12'o2000, ST_E0,1,0,0), "rst_e0");
    apply(mk(0,0,0,0,0,0,12'o2000, ST_E1,1,0,0), "rst_e1");
    apply(mk(1,1,0,0,1,1,12'o2000, ST_H0,0,0,0), "rst_in_e1");
    apply(mk(0,1,0,0,0,0,12'o7000, ST_F0,1,0,0), "rst_restart");

    // Single step: H0 after each instruction
    apply(mk(0,0,0,1,0,0,12'o7000, ST_F1,1,0,0), "ss_f1");
    apply(mk(0,0,0,1,0,0,12'o7000, ST_F2,1,0,0), "ss_f2");
    apply(mk(0,0,0,1,0,0,12'o7000, ST_F3,1,0,1), "ss_f3");
    apply(mk(0,0,0,1,0,0,12'o7000, ST_H0,0,0,0), "ss_h0_a");
    apply(mk(0,1,0,1,0,0,12'o7000, ST_F0,1,0,0), "ss_restart");
    apply(mk(0,0,0,1,0,0,12'o5177, ST_F1,1,0,0), "ss_jmp_f1");
    apply(mk(0,0,0,1,0,0,12'o5177, ST_F2,1,0,0), "ss_jmp_f2");
    apply(mk(0,0,0,1,0,0,12'o5177, ST_F3,1,0,1), "ss_jmp_f3");
    apply(mk(0,0,0,1,0,0,12'o5177, ST_H0,0,0,0), "ss_h0_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
